geofence_feeder: RTL and testbench

Input-side frame buffer for the geofence evaluator. It accepts coordinate points from a host over a valid/ready stream and groups them into 7-point frames (target first, then six receivers). Each complete frame is replayed as an unbroken 7-cycle burst on consecutive clocks, which is the serial load pattern the geofence core requires. Bursts are paced by a single credit that is returned by the core's `valid` result pulse. Two ping-pong frame banks let the host load frame N+1 while frame N is being evaluated.

---
 rtl/geofence_feeder.sv | 168 ++++++++++++++++
 tb/tb_geofence_feeder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/geofence_feeder.sv
// ----------------------------------------------------------------------------
// geofence_feeder
//
// Input-side frame buffer for the geofence evaluator. The host streams
// coordinate points over a valid/ready handshake. The points are grouped into
// 7-point frames: the target first, then six receivers. Each complete frame is
// replayed as an unbroken 7-cycle burst on consecutive clocks. Bursts are paced
// by a single credit, which the core returns with its result-valid pulse. Two
// ping-pong banks let the host load the next frame while the current one is
// being evaluated.
//
// Ports
//   clk          : single clock, rising edge
//   reset_n      : asynchronous assert, active-low reset
//   in_valid     : host point valid
//   in_ready     : feeder can accept a point (write bank not full)
//   in_x, in_y   : host point coordinates
//   out_valid    : burst point valid, 7 consecutive cycles per frame
//   out_first    : marks point 0 (target) of each burst
//   out_x, out_y : burst point coordinates (zero outside a burst)
//   gf_valid     : result pulse from the geofence core, returns the credit
//   frames_sent  : completed bursts, wraps 255 -> 0
//   err_spurious : sticky, gf_valid seen while no burst is outstanding
// ----------------------------------------------------------------------------
module geofence_feeder #(
    parameter int COORD_W = 10,
    parameter int NPTS    = 7
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    output logic               out_valid,
    output logic               out_first,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    input  logic               gf_valid,
    output logic [7:0]         frames_sent,
    output logic               err_spurious
);

    localparam int             IDX_W    = 3;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPTS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [1:0]         r_full;
    logic [1:0]         w_full_next;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [7:0]         r_frames_sent;
    logic               r_err_spurious;

    // Frame storage: two banks of NPTS points. Contents need no reset because
    // only the full flags decide what is valid.
    logic [COORD_W-1:0] r_mem_x [0:1][0:NPTS-1];
    logic [COORD_W-1:0] r_mem_y [0:1][0:NPTS-1];

    logic               w_accept;
    logic               w_wr_last;
    logic               w_rd_last;
    logic               w_in_burst;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    assign in_ready  = ~r_full[r_wr_bank];
    assign w_accept  = in_valid & ~r_full[r_wr_bank];
    assign w_wr_last = w_accept && (r_wr_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_x[r_wr_bank][r_wr_idx] <= in_x;
            r_mem_y[r_wr_bank][r_wr_idx] <= in_y;
        end
    end

    // The writer never targets a full bank, so set and clear of one bank's
    // flag can never collide even when both happen in the same cycle.
    assign w_rd_last = (r_state == ST_BURST) && (r_rd_idx == LAST_IDX);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            assign w_full_next[gi] =
                (r_full[gi] & ~(w_rd_last && (r_rd_bank == 1'(gi)))) |
                (w_wr_last && (r_wr_bank == 1'(gi)));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read-side FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (r_full[r_rd_bank]) w_state_next = ST_BURST;
            ST_BURST: if (r_rd_idx == LAST_IDX) w_state_next = ST_WAIT;
            ST_WAIT:  if (gf_valid) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_full         <= 2'b00;
            r_wr_bank      <= 1'b0;
            r_rd_bank      <= 1'b0;
            r_wr_idx       <= '0;
            r_rd_idx       <= '0;
            r_frames_sent  <= 8'd0;
            r_err_spurious <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_full  <= w_full_next;

            if (w_accept) begin
                if (w_wr_last) begin
                    r_wr_idx  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_idx  <= r_wr_idx + 3'd1;
                end
            end

            // rd_idx sits at 0 outside a burst, so a burst always starts at
            // the target point.
            if ((r_state == ST_BURST) && !w_rd_last) begin
                r_rd_idx <= r_rd_idx + 3'd1;
            end else begin
                r_rd_idx <= '0;
            end

            if (w_rd_last) begin
                r_rd_bank     <= ~r_rd_bank;
                r_frames_sent <= r_frames_sent + 8'd1;
            end

            // A credit return is only meaningful while waiting on a result.
            if (gf_valid && (r_state != ST_WAIT)) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset forces them low immediately.
    // ------------------------------------------------------------------
    assign w_in_burst   = (r_state == ST_BURST);
    assign out_valid    = w_in_burst;
    assign out_first    = w_in_burst && (r_rd_idx == '0);
    assign out_x        = w_in_burst ? r_mem_x[r_rd_bank][r_rd_idx] : '0;
    assign out_y        = w_in_burst ? r_mem_y[r_rd_bank][r_rd_idx] : '0;
    assign frames_sent  = r_frames_sent;
    assign err_spurious = r_err_spurious;

endmodule

// File: tb/tb_geofence_feeder.sv
module tb_geofence_feeder;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_x;
    logic [W-1:0] in_y;
    logic         out_valid;
    logic         out_first;
    logic [W-1:0] out_x;
    logic [W-1:0] out_y;
    logic         gf_valid;
    logic [7:0]   frames_sent;
    logic         err_spurious;

    geofence_feeder #(.COORD_W(W), .NPTS(7)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_x         (in_x),
        .in_y         (in_y),
        .out_valid    (out_valid),
        .out_first    (out_first),
        .out_x        (out_x),
        .out_y        (out_y),
        .gf_valid     (gf_valid),
        .frames_sent  (frames_sent),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         first;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } pt_t;

    pt_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  run_len = 0;
    int  bursts_seen = 0;
    int  first_cyc = -1;
    int  frame_pos = 0;
    int  last_acc = 0;
    int  exp_bursts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expected points whenever the DUT presents one.
    always @(negedge clk) begin
        pt_t e;
        if (!reset_n) begin
            run_len = 0;
        end else if (out_valid) begin
            if (out_first) begin
                if (run_len != 0) begin
                    total++; bad++;
                    $display("FAIL first_mid_burst: out_first at position %0d", run_len);
                end
                bursts_seen++;
                first_cyc = cyc;
            end
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_point: got (%0d,%0d) with empty scoreboard", out_x, out_y);
            end else begin
                e = q.pop_front();
                if (out_x !== e.x || out_y !== e.y || out_first !== e.first) begin
                    bad++;
                    $display("FAIL burst_point: got (%0d,%0d,f%0d) expected (%0d,%0d,f%0d)",
                             out_x, out_y, out_first, e.x, e.y, e.first);
                end else begin
                    $display("point (%0d,%0d) first=%0d ok", out_x, out_y, out_first);
                end
            end
            run_len++;
        end else begin
            total++;
            if (out_x !== '0 || out_y !== '0 || out_first !== 1'b0) begin
                bad++;
                $display("FAIL idle_outputs: got x=%0d y=%0d first=%0d expected 0", out_x, out_y, out_first);
            end
            if (run_len != 0) begin
                chk("burst_length", run_len, 7);
                run_len = 0;
            end
        end
    end

    // Entry/exit point of every stimulus task: #1 after a rising edge.
    task automatic send_point(input logic [W-1:0] x, input logic [W-1:0] y, input int gap);
        bit accepted = 0;
        pt_t e;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_x = x; in_y = y;
        for (int k = 0; k < 500 && !accepted; k++) begin
            @(negedge clk);
            if (in_ready) begin
                accepted = 1;
                last_acc = cyc;
                e.first = (frame_pos == 0);
                e.x = x; e.y = y;
                q.push_back(e);
                frame_pos = (frame_pos == 6) ? 0 : frame_pos + 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!accepted) begin
            total++; bad++;
            $display("FAIL input_handshake: in_ready never rose for (%0d,%0d)", x, y);
        end
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int i = 0; i < 7; i++)
            send_point(W'((base * 7 + i * 37 + 5) % 1024), W'((1000 - base * 3 - i * 11 + 2048) % 1024), gap);
    endtask

    task automatic pulse_gf(output int w);
        gf_valid = 1'b1;
        @(negedge clk); w = cyc;
        @(posedge clk); #1;
        gf_valid = 1'b0;
    endtask

    task automatic wait_bursts(input int n, input string name);
        bit ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (bursts_seen >= n && !out_valid) ok = 1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout: bursts seen %0d expected %0d", name, bursts_seen, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q.delete();
        frame_pos = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog");
    end

    logic [W-1:0] t1x [0:6];
    logic [W-1:0] t1y [0:6];
    int w, t, t2, acc_f3;

    initial begin
        t1x = '{10'd100, 10'd0, 10'd200, 10'd300, 10'd200, 10'd0, 10'd1023};
        t1y = '{10'd100, 10'd0, 10'd0,   10'd150, 10'd300, 10'd300, 10'd1023};
        reset_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; gf_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_frames_sent", int'(frames_sent), 0);
        chk("reset_err", int'(err_spurious), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: single frame, latency, then the FSM holds in WAIT.
        for (int i = 0; i < 7; i++) send_point(t1x[i], t1y[i], 0);
        t = last_acc; exp_bursts++;
        wait_bursts(exp_bursts, "single");
        chk("single_first_latency", first_cyc, t + 2);
        chk("single_frames_sent", int'(frames_sent), 1);
        send_frame(1, 0); exp_bursts++;
        repeat (15) begin @(posedge clk); #1; end
        chk("wait_holds_burst", bursts_seen, exp_bursts - 1);
        pulse_gf(w);
        wait_bursts(exp_bursts, "after_credit");
        chk("credit_to_burst", first_cyc, w + 2);
        chk("credit_no_err", int'(err_spurious), 0);
        $display("test single frame done");

        // 2: double buffering with a delayed credit.
        pulse_gf(w);
        send_frame(2, 0); t = last_acc;
        send_frame(3, 0); t2 = last_acc;
        chk("f2_packed_load", t2, t + 7);
        send_point(10'd11, 10'd22, 0); acc_f3 = last_acc;
        chk("f3_waits_for_bank", acc_f3, t2 + 2);
        for (int i = 1; i < 7; i++) send_point(W'(11 + i), W'(22 + i), 0);
        exp_bursts += 3;
        begin
            bit low = 1;
            repeat (10) begin @(negedge clk); if (in_ready) low = 0; end
            chk("both_full_in_ready_low", int'(low), 1);
            @(posedge clk); #1;
        end
        pulse_gf(w);
        while (cyc < w + 8) @(negedge clk);
        chk("in_ready_last_point", int'(in_ready), 0);
        @(negedge clk);
        chk("in_ready_after_burst", int'(in_ready), 1);
        chk("f2_burst_start", first_cyc, w + 2);
        wait_bursts(exp_bursts - 1, "f2");
        pulse_gf(w);
        wait_bursts(exp_bursts, "f3");
        chk("f3_burst_start", first_cyc, w + 2);
        chk("double_frames_sent", int'(frames_sent), 5);
        $display("test double buffering done");

        // 3: gapped input still gives a contiguous burst.
        pulse_gf(w);
        for (int i = 0; i < 7; i++) send_point(W'(500 + i * 60), W'(i * 3), (i % 2 == 1) ? 2 : 0);
        t = last_acc; exp_bursts++;
        wait_bursts(exp_bursts, "gapped");
        chk("gapped_latency", first_cyc, t + 2);
        chk("gapped_frames_sent", int'(frames_sent), 6);
        $display("test gapped input done");

        // 4: spurious credit in IDLE.
        pulse_gf(w);
        chk("err_clear_before", int'(err_spurious), 0);
        pulse_gf(w);
        repeat (10) begin @(posedge clk); #1; end
        chk("err_set", int'(err_spurious), 1);
        chk("spurious_no_burst", bursts_seen, exp_bursts);
        send_frame(4, 0); t = last_acc; exp_bursts++;
        wait_bursts(exp_bursts, "after_spurious");
        chk("after_spurious_latency", first_cyc, t + 2);
        chk("after_spurious_frames", int'(frames_sent), 7);
        chk("err_sticky", int'(err_spurious), 1);
        $display("test spurious credit done");

        // 5: reset asserted during point 3 of a burst.
        pulse_gf(w);
        send_frame(5, 0); t = last_acc;
        while (cyc < t + 5) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_frames_sent", int'(frames_sent), 0);
        chk("rst_err", int'(err_spurious), 0);
        q.delete(); frame_pos = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_bursts = bursts_seen;
        send_frame(6, 0); t = last_acc; exp_bursts++;
        wait_bursts(exp_bursts, "post_reset");
        chk("post_reset_latency", first_cyc, t + 2);
        chk("post_reset_frames", int'(frames_sent), 1);
        $display("test reset mid-burst done");

        // 6: counter wrap over 256 frames with prompt credit.
        do_reset();
        for (int f = 0; f < 256; f++) begin
            send_frame(f + 10, 0); exp_bursts++;
            wait_bursts(exp_bursts, "wrap");
            if (f == 254) chk("frames_255", int'(frames_sent), 255);
            pulse_gf(w);
        end
        chk("frames_wrap", int'(frames_sent), 0);
        chk("wrap_err", int'(err_spurious), 0);
        chk("scoreboard_empty", q.size(), 0);
        $display("test counter wrap done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
